am2910_uctrl: RTL and testbench

- Microprogram controller that sequences an am2910 sequencer instance. Holds a writable control store and the microinstruction pipeline register, and drives the sequencer's I/CCEN_BAR/CC_BAR/RLD_BAR/CI/D inputs.
- Closes the classic loop: sequencer Y addresses the control store, and the fetched word is registered and issued on the next cycle.
- Adds a start/done handshake, halt detection, fault trapping (stack overflow, address out of range, watchdog) and an issue counter.

---
 rtl/am2910_pkg.sv | 20 ++
 rtl/am2910_cstore.sv | 24 ++
 rtl/am2910_uctrl.sv | 99 +++++++++
 tb/tb_am2910_uctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/am2910_pkg.sv
// am2910_pkg: opcodes, microword layout, FSM states and fault codes shared by the microprogram controller.
package am2910_pkg;
  localparam int MW = 22;
  localparam int F_I = 0;
  localparam int F_CCEN = 4;
  localparam int F_CSEL = 5;
  localparam int F_CPOL = 7;
  localparam int F_RLD = 8;
  localparam int F_HALT = 9;
  localparam int F_D = 10;
  localparam logic [3:0] JZ = 4'd0, CJS = 4'd1, JMAP = 4'd2, CJP = 4'd3,
                         PUSH = 4'd4, JSRP = 4'd5, CJV = 4'd6, JRP = 4'd7,
                         RFCT = 4'd8, RPCT = 4'd9, CRTN = 4'd10, CJPP = 4'd11,
                         LDCT = 4'd12, LOOP = 4'd13, CONT = 4'd14, TWB = 4'd15,
                         HOLD = 4'd14;
  // CONT with CI=0, no counter load, condition disabled: sequencer stays frozen
  localparam logic [MW-1:0] HOLD_WORD = {12'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, HOLD};
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DONE, S_FAULT} state_t;
  typedef enum logic [1:0] {FLT_NONE, FLT_OVF, FLT_RANGE, FLT_WDOG} fault_t;
endpackage

// File: rtl/am2910_cstore.sv
// am2910_cstore: writable control store, synchronous read into the microinstruction pipeline register.
module am2910_cstore
  import am2910_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [MW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [MW-1:0] rdata
);
  logic [MW-1:0] mem [2**AW];
  logic [MW-1:0] rdata_q;
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= HOLD_WORD;
    else if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/am2910_uctrl.sv
// am2910_uctrl: microprogram controller driving an am2910 sequencer with start/done, fault trapping and issue count.
module am2910_uctrl
  import am2910_pkg::*;
#(
  parameter int AW = 6,
  parameter int MAX_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cs_we,
  input  logic [AW-1:0] cs_addr,
  input  logic [MW-1:0] cs_wdata,
  input  logic [3:0]    cond_in,
  input  logic [11:0]   seq_y,
  input  logic          seq_full,
  output logic [3:0]    seq_i,
  output logic          seq_ccen_bar,
  output logic          seq_cc_bar,
  output logic          seq_rld_bar,
  output logic          seq_ci,
  output logic [11:0]   seq_d,
  output logic          busy,
  output logic          done,
  output logic [1:0]    fault,
  output logic [15:0]   issued
);
  state_t        state_q, state_d;
  fault_t        fault_q, fault_d;
  logic [15:0]   issued_q, issued_d;
  logic          done_q, done_d;
  logic [MW-1:0] pipe;
  logic          ovf, range_err, wdog, go;
  am2910_cstore #(.AW(AW)) u_cstore (
    .clk   (clk),
    .rst   (rst),
    .we    (cs_we && state_q == S_IDLE),
    .waddr (cs_addr),
    .wdata (cs_wdata),
    .re    (state_q == S_CLR || go),
    .raddr (state_q == S_CLR ? '0 : seq_y[AW-1:0]),
    .rdata (pipe)
  );
  always_comb begin
    ovf       = (pipe[F_I +: 4] inside {CJS, PUSH, JSRP}) && seq_full;
    range_err = |(seq_y >> AW);
    wdog      = issued_q == 16'(MAX_CYCLES);
    go        = state_q == S_RUN && !pipe[F_HALT] && !ovf && !range_err && !wdog;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fault_q  <= FLT_NONE;
      issued_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fault_q  <= fault_d;
      issued_q <= issued_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    fault_d  = fault_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAULT: if (start) begin
        state_d  = S_CLR;
        fault_d  = FLT_NONE;
        issued_d = '0;
      end
      S_CLR: state_d = S_RUN;
      S_RUN: begin
        if (pipe[F_HALT]) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (ovf || range_err || wdog) begin
          state_d = S_FAULT;
          fault_d = ovf ? FLT_OVF : range_err ? FLT_RANGE : FLT_WDOG;
        end else issued_d = issued_q + 16'(issued_q != 16'hFFFF);
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    busy         = state_q == S_CLR || state_q == S_RUN;
    seq_i        = state_q == S_CLR ? JZ : go ? pipe[F_I +: 4] : HOLD;
    seq_ccen_bar = go ? pipe[F_CCEN] : 1'b1;
    seq_rld_bar  = go ? pipe[F_RLD] : 1'b1;
    seq_d        = go ? pipe[F_D +: 12] : 12'd0;
    seq_ci       = go;
    seq_cc_bar   = go ? ~(cond_in[pipe[F_CSEL +: 2]] ^ pipe[F_CPOL]) : 1'b1;
  end
  assign done   = done_q;
  assign fault  = fault_q;
  assign issued = issued_q;
endmodule

// File: tb/tb_am2910_uctrl.sv
// tb_am2910_uctrl: bench acts as the am2910 sequencer and predicts every issue cycle from a program-level model.
module tb_am2910_uctrl;
  localparam int AW = 6, DEPTH = 64, MAXC = 8;
  localparam logic [19:0] HOLD_V = {4'd14, 1'b1, 1'b1, 1'b0, 1'b1, 12'd0};
  logic clk = 1'b0, rst, start, cs_we, seq_full;
  logic [AW-1:0] cs_addr;
  logic [21:0] cs_wdata;
  logic [3:0] cond_in, seq_i;
  logic [11:0] seq_y, seq_d;
  logic seq_ccen_bar, seq_cc_bar, seq_rld_bar, seq_ci, busy, done;
  logic [1:0] fault;
  logic [15:0] issued;
  logic [19:0] iss_v;
  int checks = 0, passes = 0;
  logic [21:0] mem_m [DEPTH];
  logic [11:0] upc_m, rc_m;
  logic [11:0] stk_m [5];
  int sp_m;

  am2910_uctrl #(.AW(AW), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .start(start), .cs_we(cs_we), .cs_addr(cs_addr),
    .cs_wdata(cs_wdata), .cond_in(cond_in), .seq_y(seq_y), .seq_full(seq_full),
    .seq_i(seq_i), .seq_ccen_bar(seq_ccen_bar), .seq_cc_bar(seq_cc_bar),
    .seq_rld_bar(seq_rld_bar), .seq_ci(seq_ci), .seq_d(seq_d), .busy(busy),
    .done(done), .fault(fault), .issued(issued)
  );
  always #5 clk = ~clk;
  assign iss_v = {seq_i, seq_ccen_bar, seq_rld_bar, seq_ci, seq_cc_bar, seq_d};

  function automatic logic [21:0] mk(input logic [3:0] i, input logic [11:0] d,
      input logic ccen_bar = 1'b1, input logic [1:0] sel = 2'd0, input logic pol = 1'b0,
      input logic rld_bar = 1'b1, input logic halt = 1'b0);
    return {d, halt, rld_bar, pol, sel, ccen_bar, i};
  endfunction

  function automatic logic [11:0] top_m();
    return stk_m[sp_m > 0 ? sp_m - 1 : 0];
  endfunction

  task automatic push_m(input logic [11:0] v);
    if (sp_m < 5) sp_m++;
    stk_m[sp_m-1] = v;
  endtask

  // am2910 address selection for the subset of opcodes the bench programs use
  function automatic logic [11:0] next_y(input logic [21:0] w, input logic pass);
    case (w[3:0])
      4'd0: return 12'd0;
      4'd1, 4'd3: return pass ? w[21:10] : upc_m;
      4'd9: return rc_m != 0 ? w[21:10] : upc_m;
      4'd10: return pass ? top_m() : upc_m;
      default: return upc_m;
    endcase
  endfunction

  task automatic seq_apply(input logic [21:0] w, input logic pass, input logic [11:0] y);
    case (w[3:0])
      4'd0: sp_m = 0;
      4'd1: if (pass) push_m(upc_m);
      4'd4: begin push_m(upc_m); if (pass) rc_m = w[21:10]; end
      4'd9: if (rc_m != 0) rc_m--;
      4'd10: if (pass && sp_m > 0) sp_m--;
      4'd12: rc_m = w[21:10];
      default: ;
    endcase
    if (!w[8]) rc_m = w[21:10];
    upc_m = y + 12'd1;
  endtask

  task automatic cs_write(input logic [5:0] a, input logic [21:0] d, input bit taken);
    cs_we = 1'b1; cs_addr = a; cs_wdata = d;
    @(posedge clk); #1;
    cs_we = 1'b0;
    if (taken) mem_m[a] = d;
  endtask

  task automatic go_idle();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic run_prog(input string nm, input int rst_at, input int wr_at);
    logic [21:0] w, pipe_m;
    logic [11:0] y;
    logic c;
    logic [1:0] ef;
    bit term, fin;
    int iss;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    seq_y = 12'd0; seq_full = sp_m == 5; #1;
    checks++;
    if ({busy, done, fault, issued} !== {1'b1, 1'b0, 2'd0, 16'd0})
      $display("FAIL %s clr_state: got busy=%b done=%b fault=%0d issued=%0d want 1 0 0 0", nm, busy, done, fault, issued);
    else passes++;
    checks++;
    if (iss_v !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 12'd0})
      $display("FAIL %s clr_issue: got %h want %h", nm, iss_v, {4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 12'd0});
    else passes++;
    @(posedge clk); #1;
    upc_m = 12'd0; sp_m = 0; pipe_m = mem_m[0]; iss = 0; fin = 0;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      w = pipe_m;
      c = cond_in[w[6:5]] ^ w[7];
      y = next_y(w, w[4] | c);
      seq_y = y; seq_full = sp_m == 5; #1;
      ef = w[9] ? 2'd0 : ((w[3:0] inside {4'd1, 4'd4, 4'd5}) && sp_m == 5) ? 2'd1 :
           (y >= DEPTH) ? 2'd2 : (iss == MAXC) ? 2'd3 : 2'd0;
      term = w[9] || ef != 2'd0;
      if (!term && iss == rst_at) begin
        go_idle();
        checks++;
        if ({busy, done, fault, issued} !== 20'd0)
          $display("FAIL %s mid_rst: got busy=%b done=%b fault=%0d issued=%0d want all 0", nm, busy, done, fault, issued);
        else passes++;
        checks++;
        if (iss_v !== HOLD_V) $display("FAIL %s mid_rst_issue: got %h want %h", nm, iss_v, HOLD_V);
        else passes++;
        return;
      end
      if (term) begin
        checks++;
        if ({busy, iss_v} !== {1'b1, HOLD_V})
          $display("FAIL %s stop_issue cyc%0d: got busy=%b %h want 1 %h", nm, cyc, busy, iss_v, HOLD_V);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, fault, issued} !== {1'b0, w[9], ef, 16'(iss)})
          $display("FAIL %s end_state: got busy=%b done=%b fault=%0d issued=%0d want 0 %b %0d %0d", nm, busy, done, fault, issued, w[9], ef, iss);
        else passes++;
        if (w[9]) begin
          @(posedge clk); #1;
          checks++;
          if (done !== 1'b0) $display("FAIL %s done_pulse: got %b want 0", nm, done);
          else passes++;
        end
        fin = 1;
      end else begin
        checks++;
        if (iss_v !== {w[3:0], w[4], w[8], 1'b1, ~c, w[21:10]})
          $display("FAIL %s issue cyc%0d: got %h want %h", nm, cyc, iss_v, {w[3:0], w[4], w[8], 1'b1, ~c, w[21:10]});
        else passes++;
        checks++;
        if ({busy, done, fault, issued} !== {1'b1, 1'b0, 2'd0, 16'(iss)})
          $display("FAIL %s run_state cyc%0d: got busy=%b done=%b fault=%0d issued=%0d want 1 0 0 %0d", nm, cyc, busy, done, fault, issued, iss);
        else passes++;
        seq_apply(w, w[4] | c, y);
        pipe_m = mem_m[y[AW-1:0]];
        if (iss == wr_at) begin cs_we = 1'b1; cs_addr = '0; cs_wdata = mk(4'd14, 12'd0, 1, 0, 0, 1, 1); end
        iss++;
        @(posedge clk); #1;
        cs_we = 1'b0;
      end
    end
    if (!fin) begin
      checks++;
      $display("FAIL %s timeout: got no halt/fault within 100 cycles want termination", nm);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, fault, issued} !== 20'd0)
      $display("FAIL reset_state: got busy=%b done=%b fault=%0d issued=%0d want all 0", busy, done, fault, issued);
    else passes++;
    checks++;
    if (iss_v !== HOLD_V) $display("FAIL reset_issue: got %h want %h", iss_v, HOLD_V);
    else passes++;
    for (int a = 0; a < DEPTH; a++) cs_write(6'(a), mk(4'd14, 12'd0, 1, 0, 0, 1, 1), 1);
  endtask

  task automatic test_linear();
    go_idle();
    for (int a = 0; a < 3; a++) cs_write(6'(a), mk(4'd14, 12'd0), 1);
    cs_write(6'd3, mk(4'd14, 12'd0, 1, 0, 0, 1, 1), 1);
    run_prog("linear", -1, -1);
  endtask

  task automatic test_cond_jump();
    go_idle();
    cs_write(6'd0, mk(4'd3, 12'd10, 1'b0, 2'd2, 1'b0), 1);
    cs_write(6'd1, mk(4'd14, 12'd0, 1, 0, 0, 1, 1), 1);
    cs_write(6'd10, mk(4'd14, 12'd0, 1, 0, 0, 1, 1), 1);
    cond_in = 4'b0100; run_prog("cjp_taken", -1, -1);
    cond_in = 4'b0000; run_prog("cjp_fall", -1, -1);
    go_idle();
    cs_write(6'd0, mk(4'd3, 12'd10, 1'b0, 2'd1, 1'b1), 1);
    cond_in = 4'b0000; run_prog("cjp_pol", -1, -1);
  endtask

  task automatic test_overflow();
    go_idle();
    for (int a = 0; a < 6; a++) cs_write(6'(a), mk(4'd1, 12'd0), 1);
    run_prog("overflow", -1, -1);
  endtask

  task automatic test_loop();
    go_idle();
    cs_write(6'd0, mk(4'd12, 12'd3), 1);
    cs_write(6'd1, mk(4'd9, 12'd1), 1);
    cs_write(6'd2, mk(4'd14, 12'd0, 1, 0, 0, 1, 1), 1);
    run_prog("loop", -1, -1);
  endtask

  task automatic test_watchdog_range();
    go_idle();
    cs_write(6'd0, mk(4'd3, 12'd0), 1);
    run_prog("watchdog", -1, -1);
    run_prog("mid_rst", 2, -1);
    run_prog("we_in_run", -1, 1);
    cs_write(6'd0, mk(4'd14, 12'd0, 1, 0, 0, 1, 1), 0);
    run_prog("we_in_fault", -1, -1);
    go_idle();
    cs_write(6'd0, mk(4'd3, 12'd100), 1);
    run_prog("range", -1, -1);
  endtask

  task automatic test_back_to_back();
    go_idle();
    cs_write(6'd0, mk(4'd14, 12'd0), 1);
    cs_write(6'd1, mk(4'd14, 12'd0, 1, 0, 0, 1, 1), 1);
    run_prog("b2b_a", -1, -1);
    run_prog("b2b_b", -1, -1);
  endtask

  task automatic test_random();
    logic [3:0] ops [8] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd9, 4'd10, 4'd12, 4'd14};
    for (int p = 0; p < 8; p++) begin
      go_idle();
      for (int a = 0; a < DEPTH; a++)
        cs_write(6'(a), mk(ops[$urandom_range(7)],
          $urandom_range(15) == 0 ? 12'($urandom) : 12'($urandom_range(DEPTH - 1)),
          1'($urandom), 2'($urandom), 1'($urandom), $urandom_range(3) != 0,
          $urandom_range(5) == 0), 1);
      cond_in = 4'($urandom);
      run_prog($sformatf("rand%0d", p), -1, -1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cs_we = 1'b0; cs_addr = '0; cs_wdata = '0;
    cond_in = 4'd0; seq_y = 12'd0; seq_full = 1'b0;
    sp_m = 0; upc_m = 12'd0; rc_m = 12'd0;
    for (int k = 0; k < 5; k++) stk_m[k] = 12'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_linear();
    test_cond_jump();
    test_overflow();
    test_loop();
    test_watchdog_range();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
